// File: rtl/regfile_pkg.sv
// Shared constants and bus helpers for the decode-stage register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_IDX   = 0;
    localparam int BUS_MAX    = 256;
    localparam int FIELD_MAX  = 64;

    // Callers zero-extend their packed bus to BUS_MAX and cast the result down.
    function automatic logic [FIELD_MAX-1:0] port_field(
        input logic [BUS_MAX-1:0] bus,
        input int                 k,
        input int                 w
    );
        logic [BUS_MAX-1:0] s;
        s = bus >> (k * w);
        return s[FIELD_MAX-1:0];
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an in-flight producer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_addr,
    input  logic                   flush,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic                   issue_ready,
    output logic [ADDR_W:0]        busy_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DEPTH-1:0] r_busy;
    logic [ADDR_W:0]  r_count;
    logic             w_issue_zero;
    logic             w_wr_zero;
    logic             w_set;
    logic             w_clr;

    assign w_issue_zero = ZERO_REG && (issue_addr == ADDR_W'(ZERO_IDX));
    assign w_wr_zero    = ZERO_REG && (wr_addr == ADDR_W'(ZERO_IDX));

    assign issue_ready = w_issue_zero || !r_busy[issue_addr];

    // Only real bit transitions move the counter, so it cannot underflow.
    assign w_set = issue_valid && issue_ready && !w_issue_zero;
    assign w_clr = we && !w_wr_zero && r_busy[wr_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            if (w_clr) r_busy[wr_addr] <= 1'b0;
            if (w_set) r_busy[issue_addr] <= 1'b1;
            case ({w_set, w_clr})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy       = r_busy;
    assign busy_count = r_count;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-back bypass and busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_addr,
    output logic                    issue_ready,
    input  logic                    flush,
    output logic [ADDR_W:0]         busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]   w_busy;
    logic [BUS_MAX-1:0] w_addr_bus;
    logic [ADDR_W-1:0]  w_a;
    logic               w_wr_ok;

    assign w_wr_ok = we && !(ZERO_REG && (wr_addr == ADDR_W'(ZERO_IDX)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .wr_addr     (wr_addr),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .busy        (w_busy),
        .issue_ready (issue_ready),
        .busy_count  (busy_count)
    );

    always_comb begin
        w_addr_bus = '0;
        w_addr_bus[NREAD*ADDR_W-1:0] = rd_addr;
    end

    // A forwarded write also hides the busy bit it is about to clear.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        w_a     = '0;
        for (int k = 0; k < NREAD; k++) begin
            w_a = ADDR_W'(port_field(w_addr_bus, k, ADDR_W));
            if (ZERO_REG && (w_a == ADDR_W'(ZERO_IDX))) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k] = 1'b0;
            end else if (BYPASS && we && (wr_addr == w_a)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k] = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = r_regs[w_a];
                rd_busy[k] = w_busy[w_a];
            end
        end
    end

endmodule
